// File: rtl/regfile_scoreboard_if.sv
`default_nettype none
// ============================================================================
// Module   : regfile_scoreboard_if
// Purpose  : Read, issue and writeback bus of the scoreboarded register file.
//            The master side is the pipeline (decode / hazard / writeback);
//            the slave side is the register file itself.
// Revision : 1.0  initial release
// ============================================================================
interface regfile_scoreboard_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
);
  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [DATA_W-1:0] rd_data_a;
  logic [DATA_W-1:0] rd_data_b;
  logic              rd_busy_a;
  logic              rd_busy_b;
  logic              issue_valid;
  logic [ADDR_W-1:0] issue_addr;
  logic              issue_ready;
  logic              wb_valid;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic [ADDR_W:0]   pend_cnt;

  modport master (
    output rd_addr_a, rd_addr_b, issue_valid, issue_addr, wb_valid, wb_addr, wb_data,
    input  rd_data_a, rd_data_b, rd_busy_a, rd_busy_b, issue_ready, pend_cnt
  );

  modport slave (
    input  rd_addr_a, rd_addr_b, issue_valid, issue_addr, wb_valid, wb_addr, wb_data,
    output rd_data_a, rd_data_b, rd_busy_a, rd_busy_b, issue_ready, pend_cnt
  );
endinterface
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : regfile_scoreboard
// Purpose  : 2-read / 1-write register file with a per-register busy
//            scoreboard, optional hard-wired zero register and optional
//            same-cycle writeback forwarding to both read ports.
// Revision : 1.0  initial release
// ============================================================================
module regfile_scoreboard #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 3,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  wire logic             clk,
  input  wire logic             rst,
  regfile_scoreboard_if.slave   bus
);

  localparam int NREGS = 2 ** ADDR_W;
  localparam int CNT_W = ADDR_W + 1;

  logic [DATA_W-1:0] r_regs [NREGS];
  logic [NREGS-1:0]  r_busy;
  logic [CNT_W-1:0]  r_pend_cnt;

  logic w_zero_a, w_zero_b, w_zero_wb, w_zero_issue;
  logic w_wb_eff;      // writeback that actually targets a storable register
  logic w_issue_acc;   // issue handshake completes
  logic w_issue_res;   // accepted issue that really reserves a register
  logic w_fwd_a, w_fwd_b;
  logic w_cnt_inc, w_cnt_dec;

  // Register 0 is hard-wired only when the zero-register option is enabled
  assign w_zero_a     = (ZERO_REG != 0) && (bus.rd_addr_a  == '0);
  assign w_zero_b     = (ZERO_REG != 0) && (bus.rd_addr_b  == '0);
  assign w_zero_wb    = (ZERO_REG != 0) && (bus.wb_addr    == '0);
  assign w_zero_issue = (ZERO_REG != 0) && (bus.issue_addr == '0);

  assign w_wb_eff = bus.wb_valid & ~w_zero_wb;

  // A busy destination may be re-reserved in the very cycle its writeback lands
  assign bus.issue_ready = ~rst & (~r_busy[bus.issue_addr] |
                                   (bus.wb_valid & (bus.wb_addr == bus.issue_addr)));
  assign w_issue_acc = bus.issue_valid & bus.issue_ready;
  assign w_issue_res = w_issue_acc & ~w_zero_issue;

  // Forwarding is suppressed during reset because that writeback is discarded
  assign w_fwd_a = (BYPASS != 0) && !rst && w_wb_eff && (bus.wb_addr == bus.rd_addr_a);
  assign w_fwd_b = (BYPASS != 0) && !rst && w_wb_eff && (bus.wb_addr == bus.rd_addr_b);

  // A forwarded read sees busy only if a new reservation of that index lands too
  assign bus.rd_data_a = w_zero_a ? '0 : (w_fwd_a ? bus.wb_data : r_regs[bus.rd_addr_a]);
  assign bus.rd_data_b = w_zero_b ? '0 : (w_fwd_b ? bus.wb_data : r_regs[bus.rd_addr_b]);
  assign bus.rd_busy_a = w_zero_a ? 1'b0 :
                         (w_fwd_a ? (w_issue_res && (bus.issue_addr == bus.rd_addr_a))
                                  : r_busy[bus.rd_addr_a]);
  assign bus.rd_busy_b = w_zero_b ? 1'b0 :
                         (w_fwd_b ? (w_issue_res && (bus.issue_addr == bus.rd_addr_b))
                                  : r_busy[bus.rd_addr_b]);

  // Counter moves only on real busy transitions: set by a reservation, cleared by a writeback
  assign w_cnt_inc = w_issue_res;
  assign w_cnt_dec = w_wb_eff & r_busy[bus.wb_addr];

  assign bus.pend_cnt = r_pend_cnt;

  // Register storage: clear on reset, otherwise write the writeback data
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wb_eff) begin
      r_regs[bus.wb_addr] <= bus.wb_data;
    end
  end

  // Busy vector: writeback releases, an accepted issue reserves (reservation wins on same index)
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (w_issue_res && (bus.issue_addr == ADDR_W'(i))) begin
          r_busy[i] <= 1'b1;
        end else if (w_wb_eff && (bus.wb_addr == ADDR_W'(i))) begin
          r_busy[i] <= 1'b0;
        end
      end
    end
  end

  // Outstanding-reservation counter tracks the population of the busy vector
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend_cnt <= '0;
    end else if (w_cnt_inc && !w_cnt_dec) begin
      r_pend_cnt <= r_pend_cnt + 1'b1;
    end else if (!w_cnt_inc && w_cnt_dec) begin
      r_pend_cnt <= r_pend_cnt - 1'b1;
    end
  end

endmodule
`default_nettype wire
